// File: rtl/dl_port_responder_pkg.sv
// Shared types and constants for the toggle-handshake port responder.
package dl_port_responder_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] RD_ABORT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte lanes not selected by the strobes read back as all ones.
  function automatic logic [DATA_W-1:0] lane_fill(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        ds
  );
    logic [7:0] w_hi;
    logic [7:0] w_lo;
    w_hi = ds[1] ? data[15:8] : 8'hFF;
    w_lo = ds[0] ? data[7:0]  : 8'hFF;
    return {w_hi, w_lo};
  endfunction

endpackage

// File: rtl/dl_timeout_cnt.sv
// Access watchdog: counts enabled cycles and flags the cycle whose count reaches limit.
module dl_timeout_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam logic [CNT_W:0] STEP = 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_next;

  // expired is combinational so the owner can weigh it against mem_rdy in the same cycle.
  assign w_next  = {1'b0, r_cnt} + STEP;
  assign expired = en && (w_next == {1'b0, limit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= w_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/dl_port_responder.sv
// Toggle-handshake initiator port bridged to a strobe/ready memory backend with timeout.
module dl_port_responder
  import dl_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              port_req,
  output logic              port_ack,
  input  logic [ADDR_W-1:0] port_a,
  input  logic [1:0]        port_ds,
  input  logic              port_we,
  input  logic [DATA_W-1:0] port_d,
  output logic [DATA_W-1:0] port_q,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_protocol,
  output logic [15:0]       wr_count
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  state_t              r_state;
  logic                r_ack;
  logic                r_req_d;
  logic                r_busy;
  logic                r_ok;
  logic [DATA_W-1:0]   r_q;
  logic                r_mem_cs;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [1:0]          r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_err_timeout;
  logic                r_err_protocol;
  logic [15:0]         r_wr_count;

  logic w_pending;
  logic w_active;
  logic w_start;
  logic w_expired;

  assign w_pending = (port_req != r_ack);
  assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_start   = (r_state == ST_IDLE) && w_pending;

  dl_timeout_cnt #(
    .CNT_W (16)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_start),
    .en      (w_active),
    .limit   (LIMIT),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ack          <= 1'b0;
      r_req_d        <= 1'b0;
      r_busy         <= 1'b0;
      r_ok           <= 1'b0;
      r_q            <= '0;
      r_mem_cs       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_be       <= '0;
      r_mem_wdata    <= '0;
      r_err_timeout  <= 1'b0;
      r_err_protocol <= 1'b0;
      r_wr_count     <= '0;
    end else begin
      r_req_d <= port_req;
      // A request edge while busy is only recorded; the ack toggle logic ignores it.
      if (r_busy && (port_req != r_req_d)) begin
        r_err_protocol <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_mem_addr  <= port_a;
            r_mem_be    <= port_ds;
            r_mem_we    <= port_we;
            r_mem_wdata <= port_d;
            r_mem_cs    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end

        ST_ISSUE, ST_WAIT: begin
          // mem_rdy wins over an expiry landing in the same cycle.
          if (mem_rdy) begin
            r_mem_cs <= 1'b0;
            r_ok     <= 1'b1;
            if (!r_mem_we) begin
              r_q <= lane_fill(mem_rdata, r_mem_be);
            end
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_mem_cs      <= 1'b0;
            r_ok          <= 1'b0;
            r_err_timeout <= 1'b1;
            if (!r_mem_we) begin
              r_q <= RD_ABORT;
            end
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_DONE: begin
          r_ack  <= ~r_ack;
          r_busy <= 1'b0;
          if (r_mem_we && r_ok) begin
            r_wr_count <= r_wr_count + 16'd1;
          end
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign port_ack     = r_ack;
  assign port_q       = r_q;
  assign mem_cs       = r_mem_cs;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign err_protocol = r_err_protocol;
  assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_dl_port_responder.sv
// Directed self-checking bench for dl_port_responder (TIMEOUT overridden to 4).
module tb_dl_port_responder;

  localparam int unsigned ADDR_W = 23;

  logic              clk;
  logic              reset;
  logic              port_req;
  logic              port_ack;
  logic [ADDR_W-1:0] port_a;
  logic [1:0]        port_ds;
  logic              port_we;
  logic [15:0]       port_d;
  logic [15:0]       port_q;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_rdy;
  logic              busy;
  logic              err_timeout;
  logic              err_protocol;
  logic [15:0]       wr_count;

  int checks   = 0;
  int failures = 0;
  int cs_rises = 0;
  logic exp_ack;

  dl_port_responder #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_req     (port_req),
    .port_ack     (port_ack),
    .port_a       (port_a),
    .port_ds      (port_ds),
    .port_we      (port_we),
    .port_d       (port_d),
    .port_q       (port_q),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rdy      (mem_rdy),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_protocol (err_protocol),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge mem_cs) cs_rises++;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and step through the capture edge.
  task automatic start_req(input logic [ADDR_W-1:0] a, input logic [1:0] ds,
                           input logic we, input logic [15:0] d);
    port_a   = a;
    port_ds  = ds;
    port_we  = we;
    port_d   = d;
    port_req = ~port_req;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; port_req = 1'b0; port_a = '0; port_ds = '0; port_we = 1'b0;
    port_d = '0; mem_rdata = '0; mem_rdy = 1'b0;
    tick(); tick();
    checks++; if (port_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", port_ack); end
    checks++; if (port_q !== 16'h0000) begin failures++; $display("FAIL rst_q got=%h exp=0000", port_q); end
    checks++; if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_ctl got=%0b%0b exp=00", mem_cs, mem_we); end
    checks++; if (mem_addr !== '0 || mem_be !== 2'b00 || mem_wdata !== 16'h0) begin failures++; $display("FAIL rst_mem_fields got=%h/%b/%h exp=0/00/0", mem_addr, mem_be, mem_wdata); end
    checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || err_protocol !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b%0b exp=000", busy, err_timeout, err_protocol); end
    checks++; if (wr_count !== 16'h0) begin failures++; $display("FAIL rst_wrcnt got=%h exp=0000", wr_count); end
    reset = 1'b0;
    exp_ack = 1'b0;
    tick();
  endtask

  task automatic test_write();
    start_req(23'h000123, 2'b01, 1'b1, 16'hA55A);
    checks++; if (busy !== 1'b1 || mem_cs !== 1'b1) begin failures++; $display("FAIL wr_issue got busy=%0b cs=%0b exp=1/1", busy, mem_cs); end
    checks++; if (mem_we !== 1'b1 || mem_be !== 2'b01 || mem_wdata !== 16'hA55A || mem_addr !== 23'h000123) begin
      failures++; $display("FAIL wr_fields got we=%0b be=%b wd=%h a=%h exp=1/01/a55a/000123", mem_we, mem_be, mem_wdata, mem_addr); end
    tick(); tick();
    checks++; if (mem_cs !== 1'b1 || mem_wdata !== 16'hA55A) begin failures++; $display("FAIL wr_hold got cs=%0b wd=%h exp=1/a55a", mem_cs, mem_wdata); end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    checks++; if (mem_cs !== 1'b0 || port_ack !== exp_ack) begin failures++; $display("FAIL wr_done got cs=%0b ack=%0b exp=0/%0b", mem_cs, port_ack, exp_ack); end
    tick();
    exp_ack = ~exp_ack;
    checks++; if (port_ack !== exp_ack || busy !== 1'b0) begin failures++; $display("FAIL wr_ack got ack=%0b busy=%0b exp=%0b/0", port_ack, busy, exp_ack); end
    checks++; if (wr_count !== 16'h0001) begin failures++; $display("FAIL wr_count got=%h exp=0001", wr_count); end
    tick();
  endtask

  task automatic test_rdy_idle();
    mem_rdy = 1'b1;
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    checks++; if (busy !== 1'b0 || mem_cs !== 1'b0 || port_ack !== exp_ack) begin
      failures++; $display("FAIL idle_rdy got busy=%0b cs=%0b ack=%0b exp=0/0/%0b", busy, mem_cs, port_ack, exp_ack); end
  endtask

  task automatic test_read_issue();
    mem_rdata = 16'h1234;
    start_req(23'h7FFFFF, 2'b11, 1'b0, 16'h0000);
    checks++; if (mem_addr !== 23'h7FFFFF || mem_we !== 1'b0 || mem_be !== 2'b11) begin
      failures++; $display("FAIL rd_fields got a=%h we=%0b be=%b exp=7fffff/0/11", mem_addr, mem_we, mem_be); end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    checks++; if (port_ack !== exp_ack || busy !== 1'b1) begin failures++; $display("FAIL rd_early_ack got ack=%0b busy=%0b exp=%0b/1", port_ack, busy, exp_ack); end
    tick();
    exp_ack = ~exp_ack;
    checks++; if (port_ack !== exp_ack) begin failures++; $display("FAIL rd_ack3 got=%0b exp=%0b", port_ack, exp_ack); end
    checks++; if (port_q !== 16'h1234) begin failures++; $display("FAIL rd_q got=%h exp=1234", port_q); end
    checks++; if (wr_count !== 16'h0001) begin failures++; $display("FAIL rd_wrcnt got=%h exp=0001", wr_count); end
    tick();
  endtask

  task automatic test_lane_fill();
    logic [1:0]  ds_v [2] = '{2'b10, 2'b00};
    logic [15:0] q_v  [2] = '{16'hBEFF, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      mem_rdata = 16'hBEEF;
      start_req(23'h000040, ds_v[i], 1'b0, 16'h0000);
      checks++; if (mem_cs !== 1'b1 || mem_be !== ds_v[i]) begin failures++; $display("FAIL lane_be[%0d] got cs=%0b be=%b exp=1/%b", i, mem_cs, mem_be, ds_v[i]); end
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      tick();
      exp_ack = ~exp_ack;
      checks++; if (port_q !== q_v[i] || port_ack !== exp_ack) begin
        failures++; $display("FAIL lane_q[%0d] got q=%h ack=%0b exp=%h/%0b", i, port_q, port_ack, q_v[i], exp_ack); end
      tick();
    end
  endtask

  task automatic test_timeout();
    mem_rdata = 16'h5A5A;
    start_req(23'h000200, 2'b11, 1'b0, 16'h0000);
    tick(); tick(); tick();
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("FAIL tmo_edge_cs got=%0b exp=1", mem_cs); end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    checks++; if (mem_cs !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_edge_ok got cs=%0b et=%0b exp=0/0", mem_cs, err_timeout); end
    tick();
    exp_ack = ~exp_ack;
    checks++; if (port_q !== 16'h5A5A || port_ack !== exp_ack) begin failures++; $display("FAIL tmo_edge_q got q=%h ack=%0b exp=5a5a/%0b", port_q, port_ack, exp_ack); end
    tick();

    start_req(23'h000201, 2'b11, 1'b0, 16'h0000);
    tick(); tick(); tick();
    checks++; if (mem_cs !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_hold got cs=%0b et=%0b exp=1/0", mem_cs, err_timeout); end
    tick();
    checks++; if (mem_cs !== 1'b0 || err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_abort got cs=%0b et=%0b exp=0/1", mem_cs, err_timeout); end
    tick();
    exp_ack = ~exp_ack;
    checks++; if (port_q !== 16'hFFFF || port_ack !== exp_ack || busy !== 1'b0) begin
      failures++; $display("FAIL tmo_q got q=%h ack=%0b busy=%0b exp=ffff/%0b/0", port_q, port_ack, busy, exp_ack); end
    tick();

    port_q_prev_check: begin
      start_req(23'h000202, 2'b11, 1'b1, 16'h1111);
      tick(); tick(); tick(); tick(); tick();
      exp_ack = ~exp_ack;
      checks++; if (wr_count !== 16'h0001 || port_ack !== exp_ack || port_q !== 16'hFFFF) begin
        failures++; $display("FAIL tmo_wr got cnt=%h ack=%0b q=%h exp=0001/%0b/ffff", wr_count, port_ack, port_q, exp_ack); end
      tick();
    end
  endtask

  task automatic test_protocol();
    int rises0;
    rises0 = cs_rises;
    checks++; if (err_protocol !== 1'b0) begin failures++; $display("FAIL proto_pre got=%0b exp=0", err_protocol); end
    mem_rdata = 16'h0F0F;
    start_req(23'h000300, 2'b11, 1'b0, 16'h0000);
    port_req = ~port_req;
    tick();
    port_req = ~port_req;
    tick();
    checks++; if (err_protocol !== 1'b1 || busy !== 1'b1 || port_ack !== exp_ack) begin
      failures++; $display("FAIL proto_flag got ep=%0b busy=%0b ack=%0b exp=1/1/%0b", err_protocol, busy, port_ack, exp_ack); end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    tick();
    exp_ack = ~exp_ack;
    repeat (5) tick();
    checks++; if (port_ack !== exp_ack || busy !== 1'b0 || port_q !== 16'h0F0F) begin
      failures++; $display("FAIL proto_single got ack=%0b busy=%0b q=%h exp=%0b/0/0f0f", port_ack, busy, port_q, exp_ack); end
    checks++; if (cs_rises - rises0 !== 1) begin failures++; $display("FAIL proto_accesses got=%0d exp=1", cs_rises - rises0); end
  endtask

  task automatic test_wrap_and_reset();
    // Preload the counter instead of running 65535 real writes.
    force dut.r_wr_count = 16'hFFFF;
    #1;
    release dut.r_wr_count;
    tick();
    start_req(23'h000400, 2'b11, 1'b1, 16'h2222);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    tick();
    exp_ack = ~exp_ack;
    checks++; if (wr_count !== 16'h0000 || port_ack !== exp_ack) begin failures++; $display("FAIL wrap got cnt=%h ack=%0b exp=0000/%0b", wr_count, port_ack, exp_ack); end
    tick();

    port_a = 23'h000500; port_ds = 2'b11; port_we = 1'b1; port_d = 16'h3333;
    port_req = ~port_req;
    tick(); tick();
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got cs=%0b exp=1", mem_cs); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_cs !== 1'b0 || busy !== 1'b0 || port_ack !== 1'b0 || port_q !== 16'h0) begin
      failures++; $display("FAIL rst_mid got cs=%0b busy=%0b ack=%0b q=%h exp=0/0/0/0000", mem_cs, busy, port_ack, port_q); end
    checks++; if (wr_count !== 16'h0 || err_timeout !== 1'b0 || err_protocol !== 1'b0 || mem_addr !== '0 || mem_wdata !== 16'h0) begin
      failures++; $display("FAIL rst_mid_regs got cnt=%h et=%0b ep=%0b a=%h wd=%h exp=0/0/0/0/0", wr_count, err_timeout, err_protocol, mem_addr, mem_wdata); end
    port_req = 1'b1;
    port_a = 23'h000600; port_we = 1'b0;
    tick();
    reset = 1'b0;
    exp_ack = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || mem_cs !== 1'b1 || mem_addr !== 23'h000600) begin
      failures++; $display("FAIL rst_restart got busy=%0b cs=%0b a=%h exp=1/1/000600", busy, mem_cs, mem_addr); end
    mem_rdata = 16'hC3C3;
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    tick();
    checks++; if (port_ack !== 1'b1 || port_q !== 16'hC3C3) begin failures++; $display("FAIL rst_restart_ack got ack=%0b q=%h exp=1/c3c3", port_ack, port_q); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_rdy_idle();
    test_read_issue();
    test_lane_fill();
    test_timeout();
    test_protocol();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
